hb_rd_data_packer: RTL

//  Read-path stage directly downstream of the RWDS elastic buffer, in the system-clock domain.

---
 rtl/hb_rd_data_packer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hb_rd_data_packer.sv
// hb_rd_data_packer: packs 16-bit read words little-endian into DATA_WIDTH words,
// counts them against the issued length, aborts on RWDS stall, and buffers them in a show-ahead FIFO.
module hb_rd_data_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  rd_start,
    input  logic [15:0]           rd_len,
    input  logic [15:0]           din,
    input  logic                  din_vld,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_last,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic                  overflow
);
    localparam int K  = DATA_WIDTH / 16;
    localparam int LW = K > 1 ? $clog2(K) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, COLLECT} state_t;
    state_t state;

    logic [15:0]           remaining;
    logic [LW-1:0]         lane;
    logic [TW-1:0]         timer;
    logic [DATA_WIDTH-1:0] pack, pack_next, push_data;
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic [AW:0]           count;
    logic                  take, complete, expire, push, push_last, push_ok, pop, full;

    always_comb begin
        pack_next = pack;
        for (int i = 0; i < K; i++)
            if (lane == LW'(i)) pack_next[i*16 +: 16] = din;
    end

    // pack is cleared after every push, so lanes not yet written read as zero
    assign take      = state == COLLECT && din_vld;
    assign complete  = take && (lane == LW'(K-1) || remaining == 16'd1);
    assign expire    = state == COLLECT && !din_vld && timer == TW'(TIMEOUT-1);
    assign push      = complete || expire;
    assign push_data = complete ? pack_next : pack;
    assign push_last = expire || remaining == 16'd1;
    assign full      = count == (AW+1)'(FIFO_DEPTH);
    assign pop       = dout_vld && dout_rdy;
    assign push_ok   = push && (!full || pop);
    assign dout_vld  = count != '0;
    assign dout      = dout_vld ? mem_data[rptr] : '0;
    assign dout_last = dout_vld && mem_last[rptr];
    assign busy      = state == COLLECT;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state       <= IDLE;
            remaining   <= '0;
            lane        <= '0;
            timer       <= '0;
            pack        <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            if (state == IDLE) begin
                if (rd_start && rd_len == 16'd0) done <= 1'b1;
                else if (rd_start) begin
                    state     <= COLLECT;
                    remaining <= rd_len;
                    lane      <= '0;
                    timer     <= '0;
                    pack      <= '0;
                end
            end else if (take) begin
                remaining <= remaining - 16'd1;
                timer     <= '0;
                if (complete) begin
                    pack <= '0;
                    lane <= '0;
                    if (remaining == 16'd1) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end else begin
                    pack <= pack_next;
                    lane <= lane + 1'b1;
                end
            end else if (expire) begin
                timeout_err <= 1'b1;
                state       <= IDLE;
                pack        <= '0;
                lane        <= '0;
            end else
                timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push && !push_ok) overflow <= 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wptr] <= push_data;
            mem_last[wptr] <= push_last;
        end
    end
endmodule
